// File: rtl/mcp3202_spi_responder.sv
// Purpose : SPI slave modelling the MCP3202 ADC serial interface, clocked from i_clk.
// Latency : pin-to-edge SYNC_STAGES+1 clk; miso updates on the clk after a sck fall detect.
// Backpr. : none; the SPI master paces the frame, and extra sck edges after the frame are ignored.
//
// Ports:
//   i_clk, i_rst            system clock, synchronous active-high reset
//   i_sck, i_cs, i_mosi     asynchronous SPI pins from the master (i_cs active low)
//   i_ch0_data, i_ch1_data  12-bit channel sample values
//   o_miso, o_miso_oe       slave data out and its tri-state enable (synchronized ~cs)
//   o_cfg_sgl/odd/msbf      last captured command bits; o_cfg_vld pulses on MSBF capture
//   o_frame_done            pulses when the master has sampled the final data bit
//   o_busy                  FSM not idle
//   o_frame_cnt, o_abort_cnt  only when MCP3202_RESP_STATS_EN is defined
//
// Optional feature macro: MCP3202_RESP_STATS_EN (frame/abort statistics counters).
// MIN_HALF_CLKS documents the slowest-tracked sck half period; it only feeds the
// elaboration-time parameter check below.
`timescale 1ns/1ps

module mcp3202_spi_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_HALF_CLKS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sck,
  input  logic        i_cs,
  input  logic        i_mosi,
  input  logic [11:0] i_ch0_data,
  input  logic [11:0] i_ch1_data,
  output logic        o_miso,
  output logic        o_miso_oe,
  output logic        o_cfg_sgl,
  output logic        o_cfg_odd,
  output logic        o_cfg_msbf,
  output logic        o_cfg_vld,
  output logic        o_frame_done,
  output logic        o_busy
`ifdef MCP3202_RESP_STATS_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_abort_cnt
`endif
);

  // miso must settle (SYNC_STAGES+1 clk after a fall) before the master's next rise.
  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || MIN_HALF_CLKS < SYNC_STAGES + 1) begin : g_bad_param
      $error("mcp3202_spi_responder: SYNC_STAGES must be 2..3 and MIN_HALF_CLKS >= SYNC_STAGES+1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_CFG,
    S_NULLB,
    S_MSB,
    S_LSB,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------- synchronizers
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  // cs resets to its inactive (high) level so leaving reset never fakes a cs edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sck_s, w_cs_s, w_mosi_s;
  logic w_sck_rise, w_sck_fall, w_cs_rise;

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;

  // ---------------------------------------------------------------- state
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [11:0] r_sample, w_sample_nxt;
  logic        r_miso, w_miso_nxt;
  logic        r_cfg_sgl, w_cfg_sgl_nxt;
  logic        r_cfg_odd, w_cfg_odd_nxt;
  logic        r_cfg_msbf, w_cfg_msbf_nxt;
  logic        r_cfg_vld, w_cfg_vld_nxt;
  logic        r_frame_done, w_frame_done_nxt;

  // Bit select: MSB phase walks 11 down to 0, LSB phase walks 1 up to 11.
  logic [15:0] w_sample_ext;
  logic [3:0]  w_bit_idx;
  logic [3:0]  w_bit_cnt_inc;

  assign w_sample_ext  = {4'b0000, r_sample};
  assign w_bit_idx     = (r_state == S_MSB) ? (4'd11 - r_bit_cnt) : r_bit_cnt;
  assign w_bit_cnt_inc = (r_bit_cnt == 4'hF) ? r_bit_cnt : (r_bit_cnt + 4'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 4'd0;
      r_sample     <= 12'd0;
      r_miso       <= 1'b0;
      r_cfg_sgl    <= 1'b0;
      r_cfg_odd    <= 1'b0;
      r_cfg_msbf   <= 1'b0;
      r_cfg_vld    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_sample     <= w_sample_nxt;
      r_miso       <= w_miso_nxt;
      r_cfg_sgl    <= w_cfg_sgl_nxt;
      r_cfg_odd    <= w_cfg_odd_nxt;
      r_cfg_msbf   <= w_cfg_msbf_nxt;
      r_cfg_vld    <= w_cfg_vld_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_sample_nxt     = r_sample;
    w_miso_nxt       = r_miso;
    w_cfg_sgl_nxt    = r_cfg_sgl;
    w_cfg_odd_nxt    = r_cfg_odd;
    w_cfg_msbf_nxt   = r_cfg_msbf;
    w_cfg_vld_nxt    = 1'b0;
    w_frame_done_nxt = 1'b0;

    // cs deassertion takes priority over any sck edge seen on the same clk.
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
      w_miso_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_miso_nxt = 1'b0;
          if (!w_cs_s) w_state_nxt = S_WAIT_START;
        end
        S_WAIT_START: begin
          // Leading zeros before the start bit are skipped.
          if (w_sck_rise && w_mosi_s) begin
            w_state_nxt   = S_CFG;
            w_bit_cnt_nxt = 4'd0;
          end
        end
        S_CFG: begin
          if (w_sck_rise) begin
            w_bit_cnt_nxt = w_bit_cnt_inc;
            case (r_bit_cnt)
              4'd0:    w_cfg_sgl_nxt = w_mosi_s;
              4'd1:    w_cfg_odd_nxt = w_mosi_s;
              default: begin
                w_cfg_msbf_nxt = w_mosi_s;
                w_cfg_vld_nxt  = 1'b1;
                // Channel is chosen by ODD alone; SGL only affects the analog mux of a real part.
                w_sample_nxt   = r_cfg_odd ? i_ch1_data : i_ch0_data;
                w_state_nxt    = S_NULLB;
              end
            endcase
          end
        end
        S_NULLB: begin
          if (w_sck_fall) begin
            w_miso_nxt    = 1'b0;
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = S_MSB;
          end
        end
        S_MSB: begin
          if (w_sck_fall && r_bit_cnt < 4'd12) begin
            w_miso_nxt    = w_sample_ext[w_bit_idx];
            w_bit_cnt_nxt = w_bit_cnt_inc;
          end else if (w_sck_rise && r_bit_cnt == 4'd12) begin
            // Master has just sampled sample[0].
            if (r_cfg_msbf) begin
              w_frame_done_nxt = 1'b1;
              w_state_nxt      = S_DONE;
            end else begin
              w_bit_cnt_nxt = 4'd1;
              w_state_nxt   = S_LSB;
            end
          end
        end
        S_LSB: begin
          if (w_sck_fall && r_bit_cnt < 4'd12) begin
            w_miso_nxt    = w_sample_ext[w_bit_idx];
            w_bit_cnt_nxt = w_bit_cnt_inc;
          end else if (w_sck_rise && r_bit_cnt == 4'd12) begin
            w_frame_done_nxt = 1'b1;
            w_state_nxt      = S_DONE;
          end
        end
        S_DONE: begin
          if (w_sck_fall) w_miso_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_miso_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign o_miso       = r_miso;
  assign o_miso_oe    = ~w_cs_s;
  assign o_cfg_sgl    = r_cfg_sgl;
  assign o_cfg_odd    = r_cfg_odd;
  assign o_cfg_msbf   = r_cfg_msbf;
  assign o_cfg_vld    = r_cfg_vld;
  assign o_frame_done = r_frame_done;
  assign o_busy       = (r_state != S_IDLE);

`ifdef MCP3202_RESP_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_abort_cnt;
  logic        w_abort;

  // An abort is a cs release after the command started but before the frame finished.
  assign w_abort = w_cs_rise &&
                   (r_state == S_CFG || r_state == S_NULLB ||
                    r_state == S_MSB || r_state == S_LSB);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_cnt <= 16'd0;
      r_abort_cnt <= 16'd0;
    end else begin
      if (r_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_abort)      r_abort_cnt <= r_abort_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
`timescale 1ns/1ps

module tb_mcp3202_spi_responder;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic        cs;
  logic        mosi;
  logic [11:0] ch0;
  logic [11:0] ch1;
  logic        miso, miso_oe, cfg_sgl, cfg_odd, cfg_msbf, cfg_vld, frame_done, busy;
`ifdef MCP3202_RESP_STATS_EN
  logic [15:0] frame_cnt, abort_cnt;
`endif

  always #5 clk = ~clk;

  mcp3202_spi_responder #(.SYNC_STAGES(SYNC), .MIN_HALF_CLKS(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sck        (sck),
    .i_cs         (cs),
    .i_mosi       (mosi),
    .i_ch0_data   (ch0),
    .i_ch1_data   (ch1),
    .o_miso       (miso),
    .o_miso_oe    (miso_oe),
    .o_cfg_sgl    (cfg_sgl),
    .o_cfg_odd    (cfg_odd),
    .o_cfg_msbf   (cfg_msbf),
    .o_cfg_vld    (cfg_vld),
    .o_frame_done (frame_done),
    .o_busy       (busy)
`ifdef MCP3202_RESP_STATS_EN
    ,
    .o_frame_cnt  (frame_cnt),
    .o_abort_cnt  (abort_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Pulse monitors; g_drise is the number of data-phase rises the master has issued.
  int vld_cnt  = 0;
  int done_cnt = 0;
  int done_at  = 0;
  int g_drise  = 0;

  always @(negedge clk) begin
    if (cfg_vld) vld_cnt = vld_cnt + 1;
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_at  = g_drise;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: what the master reads from the first rise after MSBF onward:
  // null 0, sample MSB-first, LSB-first tail (bits 1..11) when MSBF=0, then 0s in DONE.
  function automatic logic [31:0] exp_bits(input logic [11:0] s, input bit msbf);
    logic [31:0] v;
    v = 32'd0;
    v = {v[30:0], 1'b0};
    for (int i = 11; i >= 0; i--) v = {v[30:0], s[i]};
    if (!msbf) for (int i = 1; i <= 11; i++) v = {v[30:0], s[i]};
    v = {v[29:0], 2'b00};
    return v;
  endfunction

  // SPI mode 0,0 master. action: 0 = normal end, 1 = cs abort, 2 = reset pulse.
  task automatic run_frame(input int lead, input bit sgl, input bit odd, input bit msbf,
                           input int h, input int stop_after, input int action,
                           input int chg_after, input logic [11:0] chg_val,
                           output logic [31:0] rd);
    int ncmd;
    ncmd    = lead + 4;
    rd      = 32'd0;
    g_drise = 0;
    cs = 1'b0; mosi = 1'b0; sck = 1'b0;
    wclk(h);
    for (int k = 0; k < ncmd + stop_after; k++) begin
      if (k < lead)           mosi = 1'b0;
      else if (k == lead)     mosi = 1'b1;
      else if (k == lead + 1) mosi = sgl;
      else if (k == lead + 2) mosi = odd;
      else if (k == lead + 3) mosi = msbf;
      else                    mosi = 1'($urandom_range(0, 1));
      wclk(h);
      if (k >= ncmd) begin
        rd      = {rd[30:0], miso};
        g_drise = k - ncmd + 1;
      end
      sck = 1'b1;
      wclk(h);
      sck = 1'b0;
      if (chg_after > 0 && k == ncmd - 1 + chg_after) ch0 = chg_val;
    end
    case (action)
      1: begin
        wclk(h);
        cs = 1'b1;
        wclk(SYNC + 2);
        check("abort_busy_miso_oe", {29'd0, busy, miso, miso_oe}, 32'd0);
      end
      2: begin
        rst = 1'b1;
        wclk(1);
        rst = 1'b0;
        check("midframe_reset_outputs",
              {24'd0, miso, miso_oe, cfg_sgl, cfg_odd, cfg_msbf, cfg_vld, frame_done, busy}, 32'd0);
`ifdef MCP3202_RESP_STATS_EN
        check("midframe_reset_stats", {frame_cnt, abort_cnt}, 32'd0);
`endif
        wclk(h);
        cs = 1'b1;
      end
      default: begin
        wclk(h);
        cs = 1'b1;
      end
    endcase
    wclk(h + SYNC + 6);
  endtask

  typedef struct {
    int          lead;
    bit          sgl;
    bit          odd;
    bit          msbf;
    logic [11:0] c0;
    logic [11:0] c1;
    logic [11:0] exp_s;
  } vec_t;

  initial begin : main
    vec_t        tbl[5];
    logic [31:0] rd;
    int          v0, d0, h, lead, chg;
    bit          sgl, odd, msbf;
    logic [11:0] c0, c1, cv;
    int          e_frames, e_aborts;

    e_frames = 0;
    e_aborts = 0;

    tbl[0] = '{lead: 0, sgl: 1'b1, odd: 1'b0, msbf: 1'b1, c0: 12'hA5C, c1: 12'h000, exp_s: 12'hA5C};
    tbl[1] = '{lead: 0, sgl: 1'b1, odd: 1'b1, msbf: 1'b0, c0: 12'h000, c1: 12'h3C1, exp_s: 12'h3C1};
    tbl[2] = '{lead: 3, sgl: 1'b1, odd: 1'b0, msbf: 1'b1, c0: 12'hFFF, c1: 12'h000, exp_s: 12'hFFF};
    tbl[3] = '{lead: 1, sgl: 1'b0, odd: 1'b1, msbf: 1'b1, c0: 12'hFFF, c1: 12'h5A3, exp_s: 12'h5A3};
    tbl[4] = '{lead: 2, sgl: 1'b0, odd: 1'b0, msbf: 1'b0, c0: 12'h801, c1: 12'hFFF, exp_s: 12'h801};

    rst = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0; ch0 = 12'd0; ch1 = 12'd0;
    wclk(4);
    check("reset_outputs",
          {24'd0, miso, miso_oe, cfg_sgl, cfg_odd, cfg_msbf, cfg_vld, frame_done, busy}, 32'd0);
    rst = 1'b0;
    wclk(4);
    check("idle_after_reset", {29'd0, busy, miso, miso_oe}, 32'd0);

    // Directed command/data table.
    for (int i = 0; i < 5; i++) begin
      ch0 = tbl[i].c0;
      ch1 = tbl[i].c1;
      v0 = vld_cnt; d0 = done_cnt;
      run_frame(tbl[i].lead, tbl[i].sgl, tbl[i].odd, tbl[i].msbf, HALF,
                (tbl[i].msbf ? 13 : 24) + 2, 0, 0, 12'd0, rd);
      e_frames++;
      check($sformatf("tbl%0d_data", i), rd, exp_bits(tbl[i].exp_s, tbl[i].msbf));
      check($sformatf("tbl%0d_cfg", i), {29'd0, cfg_sgl, cfg_odd, cfg_msbf},
            {29'd0, tbl[i].sgl, tbl[i].odd, tbl[i].msbf});
      check($sformatf("tbl%0d_vld_cnt", i), 32'(vld_cnt - v0), 32'd1);
      check($sformatf("tbl%0d_done_cnt", i), 32'(done_cnt - d0), 32'd1);
      check($sformatf("tbl%0d_done_at", i), 32'(done_at), tbl[i].msbf ? 32'd13 : 32'd24);
`ifdef MCP3202_RESP_STATS_EN
      check($sformatf("tbl%0d_frame_cnt", i), {16'd0, frame_cnt}, 32'(e_frames));
`endif
    end

    // Channel input changes after the command capture must not reach miso.
    ch0 = 12'h123; ch1 = 12'h000;
    d0 = done_cnt;
    run_frame(0, 1'b1, 1'b0, 1'b1, HALF, 15, 0, 3, 12'hFFF, rd);
    e_frames++;
    check("hold_data", rd, exp_bits(12'h123, 1'b1));
    check("hold_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Abort after null + 6 data bits: no frame_done, cfg retained.
    ch0 = 12'hFFF;
    d0 = done_cnt;
    run_frame(0, 1'b1, 1'b0, 1'b1, HALF, 7, 1, 0, 12'd0, rd);
    e_aborts++;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_cfg_kept", {29'd0, cfg_sgl, cfg_odd, cfg_msbf}, 32'b101);
    check("abort_partial_data", rd, {25'd0, 7'b0111111});
`ifdef MCP3202_RESP_STATS_EN
    check("abort_cnt", {16'd0, abort_cnt}, 32'(e_aborts));
`endif

    // Reset pulse in the MSB phase, then a full LSB-first frame.
    ch0 = 12'hABC;
    run_frame(0, 1'b1, 1'b0, 1'b1, HALF, 5, 2, 0, 12'd0, rd);
    e_frames = 0; e_aborts = 0;
    ch0 = 12'h000; ch1 = 12'h7E5;
    d0 = done_cnt;
    run_frame(0, 1'b0, 1'b1, 1'b0, HALF, 26, 0, 0, 12'd0, rd);
    e_frames++;
    check("post_reset_data", rd, exp_bits(12'h7E5, 1'b0));
    check("post_reset_done_cnt", 32'(done_cnt - d0), 32'd1);
`ifdef MCP3202_RESP_STATS_EN
    check("post_reset_stats", {frame_cnt, abort_cnt}, {16'(e_frames), 16'(e_aborts)});
`endif

    // Slow sck frame.
    ch0 = 12'h5A5;
    run_frame(1, 1'b1, 1'b0, 1'b1, 40, 15, 0, 0, 12'd0, rd);
    e_frames++;
    check("slow_sck_data", rd, exp_bits(12'h5A5, 1'b1));

    // Randomized frames against the reference.
    for (int i = 0; i < 8; i++) begin
      lead = $urandom_range(0, 3);
      sgl  = 1'($urandom_range(0, 1));
      odd  = 1'($urandom_range(0, 1));
      msbf = 1'($urandom_range(0, 1));
      h    = $urandom_range(4, 10);
      c0   = 12'($urandom);
      c1   = 12'($urandom);
      cv   = 12'($urandom);
      chg  = $urandom_range(1, 12);
      ch0 = c0; ch1 = c1;
      v0 = vld_cnt; d0 = done_cnt;
      run_frame(lead, sgl, odd, msbf, h, (msbf ? 13 : 24) + 2, 0, chg, cv, rd);
      e_frames++;
      check($sformatf("rnd%0d_data", i), rd, exp_bits(odd ? c1 : c0, msbf));
      check($sformatf("rnd%0d_cfg", i), {29'd0, cfg_sgl, cfg_odd, cfg_msbf}, {29'd0, sgl, odd, msbf});
      check($sformatf("rnd%0d_pulses", i), {16'(vld_cnt - v0), 16'(done_cnt - d0)}, {16'd1, 16'd1});
`ifdef MCP3202_RESP_STATS_EN
      check($sformatf("rnd%0d_frame_cnt", i), {16'd0, frame_cnt}, 32'(e_frames));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
